boolean_expression: RTL and testbench
=====================================

Name: boolean_expression

Overview:
- Evaluates the fixed 3-input Boolean function F = (A & B) | (~B & C).
- Provides the result two ways: combinationally on F, and as a registered copy with simple statistics.
- Used as a small logic leaf in the DSD exercise set. The truth-table bench drives A/B/C with no clock, so F must be purely combinational.

Parameters:
- CNT_W, default 8, width of the saturating counter of cycles in which F was 1.

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- A  input  1  operand A (MSB of minterm index).
- B  input  1  operand B.
- C  input  1  operand C (LSB of minterm index).
- F  output  1  combinational result (A&B)|(~B&C).
- F_q  output  1  F registered on clk.
- idx_q  output  3  registered minterm index {A,B,C}.
- minterm_q  output  8  registered one-hot decode of {A,B,C}; bit n set when idx = n.
- f_changed  output  1  pulses high for one cycle when the F_q register value differs from its previous value.
- ones_cnt  output  CNT_W  count of rising clk edges at which F was 1; saturates.

Behaviour:
- F is combinational, with no dependence on clk or rst, and is valid within propagation delay of any input change.
- Truth table for {A,B,C} = 000..111, in order: F = 0,1,0,0,0,1,1,1. Minterms are 1, 5, 6 and 7.
- X or Z on any input yields X on F; no X-masking is required.
- While rst = 1 (asynchronous, effective immediately): F_q = 0, idx_q = 0, minterm_q = 8'b0000_0001, f_changed = 0, ones_cnt = 0. F continues to follow its inputs during reset.
- On each rising clk edge with rst = 0:
  - F_q <= F.
  - idx_q <= {A,B,C}.
  - minterm_q <= 1 << {A,B,C}.
  - f_changed <= (F != F_q).
  - ones_cnt <= ones_cnt + 1 if F = 1 and ones_cnt is not all-ones; otherwise it holds.
- Latency: registered outputs lag the inputs by exactly one clk edge. f_changed asserts in the same cycle that F_q takes its new value.
- Saturation: ones_cnt stops at 2^CNT_W - 1 and never wraps.
- Reset released mid-stream: the first edge after deassertion compares against the reset value F_q = 0. If F = 1 at that edge, f_changed = 1.
- Reset asserted mid-operation: all registers clear immediately, with no clock edge needed.
- minterm_q is always exactly one-hot after reset.

Test Plan:
- Combinational sweep, clk idle and rst = 0: apply {A,B,C} = 000..111 with 10 ns holds. F must read 0,1,0,0,0,1,1,1.
- Reset values: assert rst with clk stopped. Immediately F_q = 0, idx_q = 0, minterm_q = 8'h01, f_changed = 0, ones_cnt = 0.
- Registered latency: release rst, apply ABC = 110, give one clk edge. Then F_q = 1, idx_q = 6, minterm_q = 8'h40, f_changed = 1, ones_cnt = 1.
- Change detect: hold ABC = 110 for a second edge, then f_changed = 0 and ones_cnt = 2. Apply 010 and clock once: F_q = 0, f_changed = 1, ones_cnt stays 2.
- Saturation with CNT_W = 3: hold ABC = 111 for 10 edges. ones_cnt must reach 7 and stay at 7.
- Async reset mid-run: with ones_cnt = 5, pulse rst between clock edges. All registered outputs clear without any edge, and F remains equal to the input-driven value.

Source files
------------

// File: rtl/boolean_expression.sv
// Three-input function F = (A & B) | (~B & C).
// F is combinational; a registered copy carries decode and statistics.
module boolean_expression #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             F,
  output logic             F_q,
  output logic [2:0]       idx_q,
  output logic [7:0]       minterm_q,
  output logic             f_changed,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0] idx;

  assign idx = {A, B, C};

  // Pure gate-level function, so X/Z on any input propagates to F.
  assign F = (A & B) | (~B & C);

  // Registered copy of F, its index and one-hot decode, plus change flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_q       <= 1'b0;
      idx_q     <= 3'd0;
      minterm_q <= 8'h01;
      f_changed <= 1'b0;
    end else begin
      F_q       <= F;
      idx_q     <= idx;
      minterm_q <= 8'h01 << idx;
      f_changed <= F ^ F_q;
    end
  end

  // Count edges at which F was high, stopping at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (F && (ones_cnt != CNT_MAX)) begin
      ones_cnt <= ones_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_boolean_expression.sv
// Directed bench for boolean_expression with a scoreboard queue.
// Small counter width so saturation is reached quickly.
module tb_boolean_expression;

  localparam int CNT_W = 3;

  typedef struct {
    logic       fq;
    logic [2:0] idx;
    logic [7:0] mt;
    logic       fc;
    logic [7:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             A;
  logic             B;
  logic             C;
  logic             F;
  logic             F_q;
  logic [2:0]       idx_q;
  logic [7:0]       minterm_q;
  logic             f_changed;
  logic [CNT_W-1:0] ones_cnt;

  exp_t sb[$];
  int   n_checks;
  int   n_err;
  logic [7:0] tt;
  logic       m_fq;
  logic [7:0] m_cnt;

  boolean_expression #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .F         (F),
    .F_q       (F_q),
    .idx_q     (idx_q),
    .minterm_q (minterm_q),
    .f_changed (f_changed),
    .ones_cnt  (ones_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fq"},  8'(F_q),       8'h00);
    chk({tag, "_idx"}, 8'(idx_q),     8'h00);
    chk({tag, "_mt"},  minterm_q,     8'h01);
    chk({tag, "_fc"},  8'(f_changed), 8'h00);
    chk({tag, "_cnt"}, 8'(ones_cnt),  8'h00);
  endtask

  task automatic step(input string tag, input logic [2:0] abc);
    exp_t e;
    logic f;
    logic [7:0] one;
    one = 8'h01;
    {A, B, C} = abc;
    f = tt[abc];
    e.fq  = f;
    e.idx = abc;
    e.mt  = one << abc;
    e.fc  = (f != m_fq);
    e.cnt = (f && m_cnt != 8'd7) ? m_cnt + 8'd1 : m_cnt;
    m_fq  = e.fq;
    m_cnt = e.cnt;
    sb.push_back(e);
    #4;
    clk = 1'b1;
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_fq"},  8'(F_q),       8'(e.fq));
      chk({tag, "_idx"}, 8'(idx_q),     8'(e.idx));
      chk({tag, "_mt"},  minterm_q,     e.mt);
      chk({tag, "_fc"},  8'(f_changed), 8'(e.fc));
      chk({tag, "_cnt"}, 8'(ones_cnt),  e.cnt);
    end
    #4;
    clk = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    tt       = 8'hE2;
    m_fq     = 1'b0;
    m_cnt    = 8'd0;
    clk      = 1'b0;
    rst      = 1'b0;
    {A, B, C} = 3'b000;

    for (int i = 0; i < 8; i++) begin
      {A, B, C} = 3'(i);
      #10;
      chk($sformatf("comb_%0d", i), 8'(F), 8'(tt[i]));
    end

    rst = 1'b1;
    #1;
    chk_reset("rst");
    #4;
    rst = 1'b0;
    m_fq  = 1'b0;
    m_cnt = 8'd0;

    step("lat110", 3'b110);
    step("hold110", 3'b110);
    step("chg010", 3'b010);
    step("run111a", 3'b111);
    step("run111b", 3'b111);
    step("run111c", 3'b111);
    chk("cnt5", 8'(ones_cnt), 8'd5);

    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    chk("arst_F", 8'(F), 8'h01);
    #2;
    rst = 1'b0;
    m_fq  = 1'b0;
    m_cnt = 8'd0;
    #5;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("sat%0d", i), 3'b111);
    end
    chk("sat_final", 8'(ones_cnt), 8'd7);

    step("tail001", 3'b001);
    step("tail100", 3'b100);
    step("tail101", 3'b101);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
